// File: rtl/smvm_pkg.sv
// rtl/smvm_pkg.sv - shared constants and FSM encoding for the result serializer
// Provides: RES_W (core result width), BYTE_W (pad byte width),
//           DEFAULT_DEPTH (FIFO entries), state_t (IDLE/RUN/FLUSH).
package smvm_pkg;
  localparam int RES_W         = 24;
  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10
  } state_t;
endpackage

// File: rtl/smvm_result_serializer_if.sv
// rtl/smvm_result_serializer_if.sv - job control, result input and byte output bundle
// Job control: start, rows_in -> busy, done, overflow, excess.
// Result input: res_valid, res_data (no backpressure).
// Byte output: byte_valid, byte_data, byte_last with byte_ready.
// Modports: slave = serializer view, master = driver/consumer view.
interface smvm_result_serializer_if
  import smvm_pkg::*;
#(
  parameter int DATA_W = RES_W,
  parameter int OUT_W  = BYTE_W,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [CNT_W-1:0]  rows_in;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              byte_valid;
  logic [OUT_W-1:0]  byte_data;
  logic              byte_last;
  logic              byte_ready;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              excess;

  modport slave (
    input  start, rows_in, res_valid, res_data, byte_ready,
    output byte_valid, byte_data, byte_last, busy, done, overflow, excess
  );

  modport master (
    output start, rows_in, res_valid, res_data, byte_ready,
    input  byte_valid, byte_data, byte_last, busy, done, overflow, excess
  );
endinterface

// File: rtl/smvm_res_fifo.sv
// rtl/smvm_res_fifo.sv - synchronous circular FIFO for core results
// Ports: clk_i, rst_i (sync, active high), push_i/wdata_i, pop_i/rdata_o,
//        full_o, empty_o. A push while full is taken when a pop happens
//        in the same cycle.
module smvm_res_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/smvm_result_serializer.sv
// rtl/smvm_result_serializer.sv - buffers SMVM row results and streams them as bytes
// Ports: clk_i, rst_i (sync, active high), bus (slave modport of
//        smvm_result_serializer_if: job control, result input, byte stream).
module smvm_result_serializer
  import smvm_pkg::*;
#(
  parameter int DATA_W = RES_W,
  parameter int OUT_W  = BYTE_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int CNT_W  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  smvm_result_serializer_if.slave  bus
);
  localparam logic [1:0] LAST_B = 2'(DATA_W / OUT_W - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  rows_q, acc_cnt_q, push_cnt_q, out_cnt_q;
  logic              ovf_q, exc_q, done_q;
  logic [DATA_W-1:0] word_q;
  logic [1:0]        b_q;
  logic              ser_vld_q;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic              hs, last_hs, ser_free, take, room, drop;

  always_comb begin
    hs        = ser_vld_q && bus.byte_ready;
    last_hs   = hs && (b_q == LAST_B);
    // The serializer can take a new word when empty or finishing its last byte.
    ser_free  = !ser_vld_q || last_hs;
    fifo_pop  = !fifo_empty && ser_free;
    room      = acc_cnt_q < rows_q;
    take      = (state_q != IDLE) && bus.res_valid && room;
    fifo_push = take && (!fifo_full || fifo_pop);
    drop      = take && fifo_full && !fifo_pop;
  end

  smvm_res_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (bus.res_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rows_q     <= '0;
      acc_cnt_q  <= '0;
      push_cnt_q <= '0;
      out_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      exc_q      <= 1'b0;
      done_q     <= 1'b0;
      word_q     <= '0;
      b_q        <= '0;
      ser_vld_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Serializer: the word is shifted so the current byte is always on top.
      if (fifo_pop) begin
        word_q    <= fifo_rdata;
        b_q       <= '0;
        ser_vld_q <= 1'b1;
      end else if (hs) begin
        if (b_q == LAST_B) begin
          ser_vld_q <= 1'b0;
        end else begin
          word_q <= word_q << OUT_W;
          b_q    <= b_q + 1'b1;
        end
      end
      if (last_hs) out_cnt_q <= out_cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.rows_in != '0) begin
              rows_q     <= bus.rows_in;
              acc_cnt_q  <= '0;
              push_cnt_q <= '0;
              out_cnt_q  <= '0;
              ovf_q      <= 1'b0;
              exc_q      <= 1'b0;
              state_q    <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN, FLUSH: begin
          if (take) acc_cnt_q <= acc_cnt_q + 1'b1;
          if (fifo_push) push_cnt_q <= push_cnt_q + 1'b1;
          if (drop) ovf_q <= 1'b1;
          if (bus.res_valid && !room) exc_q <= 1'b1;
          if (state_q == RUN) begin
            if (take && (CNT_W'(acc_cnt_q + 1'b1) == rows_q)) state_q <= FLUSH;
          end else if (fifo_empty && !ser_vld_q && (out_cnt_q == push_cnt_q)) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.byte_valid = ser_vld_q;
  assign bus.byte_data  = word_q[DATA_W-1 -: OUT_W];
  assign bus.byte_last  = ser_vld_q && (b_q == LAST_B);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.overflow   = ovf_q;
  assign bus.excess     = exc_q;
endmodule

// File: tb/tb_smvm_result_serializer.sv
// tb/tb_smvm_result_serializer.sv - scoreboard bench for smvm_result_serializer
module tb_smvm_result_serializer;
  import smvm_pkg::*;

  localparam int DEPTH = DEFAULT_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_hs = 0;
  int   done_cyc = 0;

  // Expected byte stream: {last, byte}.
  logic [8:0] exp_q[$];
  int   job_rows = 0, job_acc = 0, job_held = 0;
  bit   active = 0, exp_ovf = 0, exp_exc = 0, rand_ready = 0;

  bit         stall = 0;
  logic [8:0] saved = '0;

  smvm_result_serializer_if #(.DATA_W(24), .OUT_W(8), .CNT_W(8)) bus ();

  smvm_result_serializer #(.DATA_W(24), .OUT_W(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      stall = 0;
    end else begin
      if (stall) begin
        check("hold_valid", 32'(bus.byte_valid), 32'd1);
        check("hold_data", 32'({bus.byte_last, bus.byte_data}), 32'(saved));
      end
      if (bus.byte_valid && bus.byte_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", bus.byte_data);
        end else begin
          check("byte", 32'({bus.byte_last, bus.byte_data}), 32'(exp_q.pop_front()));
        end
        last_hs = cyc + 1;
      end
      stall = bus.byte_valid && !bus.byte_ready;
      saved = {bus.byte_last, bus.byte_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.byte_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_job(input int n);
    bus.start   = 1'b1;
    bus.rows_in = 8'(n);
    tick();
    bus.start = 1'b0;
    if (n > 0 && !active) begin
      active   = 1;
      job_rows = n;
      job_acc  = 0;
      job_held = 0;
      exp_ovf  = 0;
      exp_exc  = 0;
    end
  endtask

  // Reference rule: a job holds at most DEPTH+1 results when nothing drains
  // during injection; extra rows beyond that are dropped but still counted.
  task automatic put_result(input logic [23:0] d);
    if (active) begin
      if (job_acc < job_rows) begin
        job_acc++;
        if (job_held < DEPTH + 1) begin
          exp_q.push_back({1'b0, d[23:16]});
          exp_q.push_back({1'b0, d[15:8]});
          exp_q.push_back({1'b1, d[7:0]});
          job_held++;
        end else begin
          exp_ovf = 1;
        end
      end else begin
        exp_exc = 1;
      end
    end
    bus.res_valid = 1'b1;
    bus.res_data  = d;
    tick();
  endtask

  task automatic wait_done(input string name);
    bit found = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (bus.done) begin
        found    = 1;
        done_cyc = cyc;
        break;
      end
    end
    check({name, "_done"}, 32'(found), 32'd1);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
    check({name, "_exc"}, 32'(bus.excess), 32'(exp_exc));
    active = 0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.rows_in    = '0;
    bus.res_valid  = 1'b0;
    bus.res_data   = '0;
    bus.byte_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(bus.byte_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_exc", 32'(bus.excess), 32'd0);
    rst = 1'b0;
    tick();

    // Two back-to-back results, ready always high.
    bus.byte_ready = 1'b1;
    start_job(2);
    check("t1_busy", 32'(bus.busy), 32'd1);
    put_result(24'h123456);
    check("t1_lat_pre", 32'(bus.byte_valid), 32'd0);
    put_result(24'hFEDCBA);
    check("t1_lat_first", 32'(bus.byte_valid), 32'd1);
    bus.res_valid = 1'b0;
    wait_done("t1");
    check("t1_done_after_last", 32'(done_cyc - last_hs), 32'd1);

    // Stalled output byte must hold.
    bus.byte_ready = 1'b0;
    start_job(1);
    put_result(24'h800001);
    bus.res_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.byte_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_valid", 32'(bus.byte_valid), 32'd1);
      check("t2_stall_byte", 32'(bus.byte_data), 32'h80);
      tick();
    end
    bus.byte_ready = 1'b1;
    wait_done("t2");

    // Overflow: 12 rows with output blocked.
    bus.byte_ready = 1'b0;
    start_job(12);
    for (int i = 0; i < 12; i++) put_result(24'(32'hA00000 + i * 32'h010203));
    bus.res_valid = 1'b0;
    tick();
    check("t3_ovf", 32'(bus.overflow), 32'd1);
    bus.byte_ready = 1'b1;
    wait_done("t3");

    // Excess result.
    start_job(1);
    put_result(24'h0BEEF0);
    put_result(24'h777777);
    bus.res_valid = 1'b0;
    wait_done("t4");

    // Zero-row job.
    start_job(0);
    check("t5_done", 32'(bus.done), 32'd1);
    check("t5_busy", 32'(bus.busy), 32'd0);
    tick();
    check("t5_done_off", 32'(bus.done), 32'd0);
    check("t5_no_byte", 32'(bus.byte_valid), 32'd0);

    // Reset mid-stream after two bytes.
    bus.byte_ready = 1'b0;
    start_job(1);
    put_result(24'hABCDEF);
    bus.res_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.byte_valid; i++) tick();
    bus.byte_ready = 1'b1;
    tick();
    tick();
    bus.byte_ready = 1'b0;
    rst = 1'b1;
    check("t6_left", 32'(exp_q.size()), 32'd1);
    tick();
    check("t6_valid", 32'(bus.byte_valid), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_done", 32'(bus.done), 32'd0);
    exp_q.delete();
    active  = 0;
    exp_ovf = 0;
    exp_exc = 0;
    rst = 1'b0;
    tick();
    bus.byte_ready = 1'b1;
    start_job(1);
    put_result(24'h000007);
    bus.res_valid = 1'b0;
    wait_done("t6b");

    // Randomized jobs with random output backpressure.
    rand_ready = 1;
    for (int j = 0; j < 25; j++) begin
      int n;
      bit extra;
      if ($urandom_range(0, 3) == 0) begin
        put_result(24'($urandom));
        bus.res_valid = 1'b0;
        check("idle_ignore_exc", 32'(bus.excess), 32'(exp_exc));
      end
      n     = $urandom_range(1, 9);
      extra = ($urandom_range(0, 2) == 0);
      start_job(n);
      for (int k = 0; k < n; k++) begin
        put_result(24'($urandom));
        if (k < n - 1) begin
          bus.res_valid = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      if (extra) put_result(24'($urandom));
      bus.res_valid = 1'b0;
      wait_done("rnd");
    end
    rand_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/smvm_result_serializer.md
Name: smvm_result_serializer

Overview:
- Downstream stage of the SMVM core. It consumes one 24-bit signed row result per out_valid pulse and buffers results in a small FIFO, because the core has no backpressure.
- It emits each result as three bytes, MSB first, on an 8-bit valid/ready stream toward the chip output pads.
- It counts results against the row count latched at job start, pulses done after the last byte, and flags overflow and excess results.

Parameters:
- DATA_W, 24, result width from the SMVM core (must equal 3*OUT_W).
- OUT_W, 8, output byte width.
- DEPTH, 8, FIFO entries (power of 2).
- CNT_W, 8, width of the row counter and the rows field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start; samples rows_in.
- rows_in  in  CNT_W  number of result rows expected in this job.
- res_valid  in  1  core out_valid; one result per high cycle.
- res_data  in  DATA_W  core data_out (signed).
- byte_valid  out  1  output byte valid.
- byte_data  out  OUT_W  output byte.
- byte_last  out  1  high on the third byte of each result.
- byte_ready  in  1  downstream accepts the byte when valid && ready.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at job completion.
- overflow  out  1  sticky; a result was dropped because the FIFO was full.
- excess  out  1  sticky; a result arrived after rows results had already been accepted.

Behaviour:
- Reset (rst high at posedge): all outputs 0, FSM=IDLE, FIFO empty, counters 0. A reset mid-job discards FIFO and serializer contents, and no done pulse is produced.
- FSM has states IDLE, RUN, FLUSH.
- IDLE:
  - start with rows_in>0: latch rows, clear acc_cnt, out_cnt, overflow and excess, then go to RUN.
  - start with rows_in==0: pulse done next cycle and stay in IDLE.
  - res_valid is ignored in IDLE and no flag is set.
- RUN: each res_valid cycle:
  - acc_cnt<rows and FIFO not full: push, acc_cnt++.
  - acc_cnt<rows and FIFO full with no pop this cycle: drop, set overflow, acc_cnt++ (the row is still counted).
  - FIFO full with a pop this same cycle: push is accepted.
  - acc_cnt==rows: ignore, set excess.
  - Go to FLUSH when acc_cnt reaches rows.
- FLUSH:
  - Same res_valid handling as RUN (any result sets excess).
  - When FIFO empty, serializer idle and out_cnt==accepted-result count, pulse done for one cycle and return to IDLE.
- busy is high in RUN and FLUSH.
- start while busy is ignored.
- Serializer:
  - Holds one word and byte index b in {0,1,2}.
  - When idle and FIFO non-empty, it pops the FIFO at the clock edge. byte_valid rises the next cycle.
  - Latency from the res_valid edge to first byte_valid is 2 cycles with an empty pipeline.
  - Byte b = word[DATA_W-1-8b -: 8].
  - On valid&&ready: b++. At b==2, byte_last=1; that handshake increments out_cnt and either loads the next FIFO word in the same edge (back-to-back, no bubble) or goes idle.
  - While !byte_ready, byte_data, byte_last and byte_valid hold stable. byte_valid never drops without a handshake.
- FIFO:
  - Circular buffer with log2(DEPTH)+1-bit pointers; full when MSBs differ and LSBs are equal.
  - Wrap-around is transparent.
- Counters are CNT_W wide and never exceed rows; excess prevents wrap.
- overflow and excess stay set until the next accepted start or rst.

Decomposition:
- Shared package smvm_pkg holds:
  - constants RES_W=24 and BYTE_W=8;
  - state encoding IDLE=2'b00, RUN=2'b01, FLUSH=2'b10;
  - default DEPTH.
- One sub-module, smvm_res_fifo (synchronous FIFO with push, pop, full, empty and same-cycle push/pop when full), is instantiated once.
- The FSM and serializer stay in the top.

Test Plan:
- rows_in=2; results 24'h123456, 24'hFEDCBA back-to-back; byte_ready=1 -> bytes 12,34,56,FE,DC,BA; byte_last on 56 and BA; first byte_valid 2 cycles after the first res_valid; done pulses one cycle after the BA handshake; busy then 0.
- rows_in=1; result 24'h800001; byte_ready held low 5 cycles after byte_valid -> byte 80 held stable with valid high; bytes 80,00,01 follow once ready rises.
- rows_in=12; 12 consecutive results with byte_ready=0 -> FIFO holds 8 and the serializer holds 1; overflow=1; drain yields 9 results (27 bytes); done still pulses.
- rows_in=1; two results -> second sets excess=1; only 3 bytes out; done pulses.
- rows_in=0 start -> done pulses next cycle; busy never rises; no bytes.
- rst asserted mid-stream after byte 2 of 3 -> next cycle byte_valid=0, busy=0, done=0; a new start with rows_in=1 and result 24'h000007 yields 00,00,07.
